// File: rtl/tx_framer.sv
// tx_framer: latches one frame on a start handshake and shifts sync+header+payload+CRC-16 out MSB first.
module tx_framer #(
  parameter int          PAYLOAD_W = 128,
  parameter logic [15:0] CRC_POLY  = 16'h1021,
  parameter logic [15:0] CRC_INIT  = 16'hFFFF,
  parameter logic [7:0]  SYNC_WORD = 8'h7E
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [1:0]           dest_id,
  input  logic [1:0]           src_id,
  input  logic [PAYLOAD_W-1:0] payload,
  input  logic                 corrupt_crc,
  output logic                 ready,
  output logic                 tx_line,
  output logic                 tx_active,
  output logic                 done
);
  typedef enum logic [2:0] {IDLE, SYNC, HDR, DATA, CRC, DONE} state_t;
  localparam int CW = $clog2(PAYLOAD_W > 16 ? PAYLOAD_W : 16);
  localparam int SW = PAYLOAD_W + 11;
  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_load;
  logic [SW-1:0]   sr;
  logic [15:0]     crc, crc_nxt;
  logic            corrupt, last;
  assign last    = cnt == '0;
  // tx_line holds the bit currently on the wire, so the CRC absorbs it directly
  assign crc_nxt = {crc[14:0], 1'b0} ^ ((tx_line ^ crc[15]) ? CRC_POLY : 16'h0);
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = start ? SYNC : IDLE;
      SYNC:    state_nxt = last ? HDR : SYNC;
      HDR:     state_nxt = last ? DATA : HDR;
      DATA:    state_nxt = last ? CRC : DATA;
      CRC:     state_nxt = last ? DONE : CRC;
      default: state_nxt = IDLE;
    endcase
    cnt_load = state_nxt == SYNC ? CW'(7) :
               state_nxt == HDR  ? CW'(3) :
               state_nxt == DATA ? CW'(PAYLOAD_W - 1) :
               state_nxt == CRC  ? CW'(15) : '0;
  end
  always_comb begin
    ready     = state == IDLE;
    done      = state == DONE;
    tx_active = state inside {SYNC, HDR, DATA, CRC};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      sr      <= '0;
      crc     <= CRC_INIT;
      corrupt <= 1'b0;
      tx_line <= 1'b0;
    end else begin
      cnt <= state_nxt != state ? cnt_load : last ? cnt : cnt - 1'b1;
      if (state == IDLE && start) begin
        sr      <= {SYNC_WORD[6:0], dest_id, src_id, payload};
        corrupt <= corrupt_crc;
        tx_line <= SYNC_WORD[7];
        crc     <= CRC_INIT;
      end else if (state == SYNC || state == HDR || (state == DATA && !last)) begin
        tx_line <= sr[SW-1];
        sr      <= {sr[SW-2:0], 1'b0};
        if (state != SYNC) crc <= crc_nxt;
      end else if (state == DATA) begin
        tx_line <= crc_nxt[15];
        crc     <= {crc_nxt[14:0], 1'b0};
      end else if (state == CRC) begin
        // cnt==1 is the cycle that loads the final CRC bit onto the line
        tx_line <= !last && (crc[15] ^ (corrupt && cnt == CW'(1)));
        crc     <= {crc[14:0], 1'b0};
      end else begin
        tx_line <= 1'b0;
        crc     <= CRC_INIT;
      end
    end
  end
endmodule

// File: tb/tb_tx_framer.sv
// tb_tx_framer: randomized and directed frames checked against a frame-vector model every cycle.
module tb_tx_framer;
  logic         clk = 0, rst = 1, start = 0, corrupt_crc = 0;
  logic [1:0]   dest_id = 0, src_id = 0;
  logic [127:0] payload = 0;
  logic         ready, tx_line, tx_active, done;
  int           checks = 0, errors = 0;
  logic         chk_en = 0;
  int           k = 0;
  logic [155:0] fv;
  logic         cap [1:156];
  logic         cap1 [1:156];

  tx_framer dut (.clk(clk), .rst(rst), .start(start), .dest_id(dest_id), .src_id(src_id),
                 .payload(payload), .corrupt_crc(corrupt_crc), .ready(ready), .tx_line(tx_line),
                 .tx_active(tx_active), .done(done));

  always #5 clk = ~clk;

  function automatic logic [15:0] crc_bits(input logic [131:0] v, input int n);
    logic [15:0] c = 16'hFFFF;
    for (int i = n - 1; i >= 0; i--) c = {c[14:0], 1'b0} ^ ((v[i] ^ c[15]) ? 16'h1021 : 16'h0);
    return c;
  endfunction

  function automatic logic [155:0] frame(input logic [1:0] d, input logic [1:0] s,
                                         input logic [127:0] p, input logic corr);
    logic [131:0] hp = {d, s, p};
    logic [15:0]  c  = crc_bits(hp, 132);
    c[0] = c[0] ^ corr;
    return {8'h7E, hp, c};
  endfunction

  function automatic logic [15:0] capv(input int lo, input int n);
    logic [15:0] r = 0;
    for (int i = 0; i < n; i++) r = {r[14:0], cap[lo + i]};
    return r;
  endfunction

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: k=0 idle, k=1..156 frame bit k on the line, k=157 done cycle.
  always @(posedge clk) begin
    if (rst) k = 0;
    else if (k == 0) begin
      if (start) begin
        fv = frame(dest_id, src_id, payload, corrupt_crc);
        k = 1;
      end
    end else k = (k == 157) ? 0 : k + 1;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("ready", {15'b0, ready}, {15'b0, k == 0});
      check("tx_active", {15'b0, tx_active}, {15'b0, k >= 1 && k <= 156});
      check("done", {15'b0, done}, {15'b0, k == 157});
      check("tx_line", {15'b0, tx_line}, {15'b0, (k >= 1 && k <= 156) ? fv[156 - k] : 1'b0});
      if (k >= 1 && k <= 156) cap[k] = tx_line;
    end
  end

  task automatic wait_ready();
    int t = 0;
    while (!ready && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (t >= 300) check("ready_timeout", 16'd0, 16'd1);
  endtask

  task automatic send(input logic [1:0] d, input logic [1:0] s, input logic [127:0] p,
                      input logic c, input bit noisy);
    @(negedge clk);
    wait_ready();
    dest_id = d; src_id = s; payload = p; corrupt_crc = c; start = 1;
    @(negedge clk);
    start = 0;
    for (int i = 0; i < 158; i++) begin
      if (noisy) begin
        dest_id = 2'($urandom); src_id = 2'($urandom);
        payload = {$urandom, $urandom, $urandom, $urandom};
        corrupt_crc = 1'($urandom); start = 1'($urandom);
      end
      @(negedge clk);
    end
    start = 0;
  endtask

  initial begin
    int dones, rise1, rise2, nrise;
    logic prev;
    check("crc_pin", crc_bits({60'b0, 72'h313233343536373839}, 72), 16'h29B1);
    repeat (3) @(negedge clk);
    chk_en = 1;
    rst = 0;
    repeat (20) @(negedge clk);

    send(2'b01, 2'b10, 128'hA5, 0, 0);
    check("sync_bits", capv(1, 8), 16'h007E);
    check("hdr_bits", capv(9, 4), 16'h0006);
    check("payload_tail", capv(133, 8), 16'h00A5);
    for (int i = 1; i <= 156; i++) cap1[i] = cap[i];

    send(2'b01, 2'b10, 128'hA5, 1, 0);
    begin
      int diff = 0;
      for (int i = 1; i <= 155; i++) if (cap[i] !== cap1[i]) diff++;
      check("corrupt_same_prefix", 16'(diff), 16'd0);
      check("corrupt_last_bit", {15'b0, cap[156]}, {15'b0, ~cap1[156]});
    end

    @(negedge clk);
    wait_ready();
    dest_id = 2'b10; src_id = 2'b01; payload = {4{$urandom}}; corrupt_crc = 0;
    start = 1;
    dones = 0; nrise = 0; rise1 = 0; rise2 = 0; prev = tx_active;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (done) dones++;
      if (tx_active && !prev) begin
        if (nrise == 0) rise1 = i;
        if (nrise == 1) rise2 = i;
        nrise++;
      end
      prev = tx_active;
    end
    start = 0;
    check("held_start_frames", 16'(dones), 16'd2);
    check("held_start_gap", 16'(rise2 - rise1), 16'd158);
    repeat (200) @(negedge clk);

    @(negedge clk);
    wait_ready();
    dest_id = 2'b11; src_id = 2'b00; payload = {4{$urandom}}; start = 1;
    @(negedge clk);
    start = 0;
    repeat (59) @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    check("abort_ready", {15'b0, ready}, 16'd1);
    check("abort_line", {15'b0, tx_line}, 16'd0);
    repeat (5) @(negedge clk);
    send(2'b00, 2'b11, {4{$urandom}}, 0, 0);

    send(2'b11, 2'b11, {128{1'b1}}, 0, 0);

    for (int n = 0; n < 15; n++) begin
      repeat ($urandom_range(0, 5)) @(negedge clk);
      send(2'($urandom), 2'($urandom), {$urandom, $urandom, $urandom, $urandom},
           1'($urandom), 1'($urandom));
    end
    repeat (200) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
